// File: rtl/instr_fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_fetch_mem.sv
// Instruction memory: one write port, one registered read port whose output
// register is the IF/ID instruction; out-of-range word indices read as halt.
module instr_mem #(
  parameter int WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W = 30,
  parameter int AW = 8,
  parameter logic [WIDTH-1:0] HALT_WORD = '1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_en,
  input  logic             rd_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_is_halt
);
  import instr_fetch_pkg::*;

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic             in_range;
  logic [WIDTH-1:0] word;

  assign in_range = rd_idx < IDX_W'(MEM_DEPTH);

  always_comb begin
    word = HALT_WORD;
    if (in_range) word = mem[rd_idx[AW-1:0]];
  end

  // The halt comparator looks at the addressed word before it is registered so
  // the PC stage can stop in the same cycle the halt is being fetched.
  assign rd_is_halt = (word == HALT_WORD);

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_clr)     rd_data <= WIDTH'(NOP);
    else if (rd_en) rd_data <= word;
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: byte-serial program loader, instruction fetch into IF/ID, and
// halt detection that drives the PC stage's end input.
module instr_fetch #(
  parameter int bitsPC = 32,
  parameter int MEM_DEPTH = 256,
  parameter logic [bitsPC-1:0] HALT_WORD = bitsPC'(instr_fetch_pkg::HALT_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              db_ena,
  input  logic              flush,
  input  logic [bitsPC-1:0] pc,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic [bitsPC-1:0] instr,
  output logic [bitsPC-1:0] pc_plus4,
  output logic              if_valid,
  output logic              pc_end,
  output logic              ld_ready
);
  import instr_fetch_pkg::*;

  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IDX_W = bitsPC - 2;

  state_e            state;
  logic [AW-1:0]     wr_ptr;
  logic [1:0]        byte_cnt;
  logic [23:0]       byte_buf;
  logic [31:0]       next_word;
  logic [bitsPC-1:0] wr_word;
  logic              word_done;
  logic              last_slot;
  logic              advance;
  logic              rd_clr;
  logic              rd_is_halt;
  logic              unused_pc_bits;

  // Loader handshake: ld_valid is a one-cycle byte strobe with no backpressure;
  // bytes are consumed only while ld_ready (LOAD) is high, otherwise dropped.
  // The first three bytes of a word are buffered; the fourth completes it.
  assign next_word = {byte_buf, ld_byte};
  assign wr_word   = bitsPC'(next_word);
  assign word_done = (state == ST_LOAD) && ld_valid && (byte_cnt == 2'd3);
  assign last_slot = (wr_ptr == AW'(MEM_DEPTH - 1));

  assign advance = (state == ST_RUN) && db_ena && !flush && ena;
  assign rd_clr  = !reset ||
                   (db_ena && (((state == ST_RUN) && flush) || (state == ST_DONE)));

  assign unused_pc_bits = ^pc[1:0];

  instr_mem #(
    .WIDTH     (bitsPC),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W),
    .AW        (AW),
    .HALT_WORD (HALT_WORD)
  ) u_mem (
    .clk        (clk),
    .we         (word_done),
    .wr_addr    (wr_ptr),
    .wr_data    (wr_word),
    .rd_idx     (pc[bitsPC-1:2]),
    .rd_en      (advance),
    .rd_clr     (rd_clr),
    .rd_data    (instr),
    .rd_is_halt (rd_is_halt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_LOAD;
      wr_ptr   <= '0;
      byte_cnt <= '0;
      byte_buf <= '0;
      pc_plus4 <= '0;
      if_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_valid) begin
            byte_buf <= next_word[23:0];
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              wr_ptr   <= wr_ptr + AW'(1);
              if ((wr_word == HALT_WORD) || last_slot) state <= ST_RUN;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (db_ena) begin
            if (flush) begin
              if_valid <= 1'b0;
            end else if (ena) begin
              pc_plus4 <= pc + bitsPC'(4);
              if_valid <= 1'b1;
              if (rd_is_halt) state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (db_ena) if_valid <= 1'b0;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign pc_end   = ((state == ST_RUN) && rd_is_halt) || (state == ST_DONE);
  assign ld_ready = (state == ST_LOAD);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// load/run traffic compared against a behavioural reference model.
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b0;
  logic        db_ena = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        pc_end;
  logic        ld_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .db_ena   (db_ena),
    .flush    (flush),
    .pc       (pc),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .instr    (instr),
    .pc_plus4 (pc_plus4),
    .if_valid (if_valid),
    .pc_end   (pc_end),
    .ld_ready (ld_ready)
  );

  // Reference model: memory image, pending loader bytes, program phase flags.
  logic [31:0] m_mem [256];
  logic [7:0]  m_bytes [$];
  logic [31:0] exp_q [$];
  bit          m_loaded = 1'b0;
  bit          m_halted = 1'b0;
  int          m_wr = 0;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_pp4 = '0;
  logic        exp_valid = 1'b0;

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    if (a[31:2] >= 30'd256) return HALT;
    return m_mem[a[9:2]];
  endfunction

  function automatic logic m_pc_end();
    if (m_halted) return 1'b1;
    if (!m_loaded) return 1'b0;
    return m_fetch(pc) == HALT;
  endfunction

  task automatic model_edge();
    logic [31:0] w;
    if (!reset) begin
      m_loaded = 1'b0; m_halted = 1'b0; m_wr = 0; m_bytes.delete();
      exp_instr = '0; exp_pp4 = '0; exp_valid = 1'b0;
    end else if (!m_loaded) begin
      if (ld_valid) begin
        m_bytes.push_back(ld_byte);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_mem[m_wr] = w;
          m_bytes.delete();
          if (w == HALT || m_wr == 255) m_loaded = 1'b1;
          m_wr++;
        end
      end
    end else if (!m_halted) begin
      if (db_ena) begin
        if (flush) begin
          exp_instr = '0; exp_valid = 1'b0;
        end else if (ena) begin
          w = m_fetch(pc);
          exp_instr = w; exp_pp4 = pc + 32'd4; exp_valid = 1'b1;
          if (w == HALT) m_halted = 1'b1;
        end
      end
    end else if (db_ena) begin
      exp_instr = '0; exp_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic f,
                       input logic [31:0] p, input logic lv, input logic [7:0] lb);
    reset = r; ena = e; db_ena = d; flush = f; pc = p; ld_valid = lv; ld_byte = lb;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    tick();
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, w[b*8 +: 8]);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 1'b1, 8'hA5);
    tick();
    tick();
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    checks++; if (pc_end !== 1'b0) begin failures++; $display("FAIL reset_pc_end got=%b exp=0", pc_end); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
  endtask

  task automatic test_load();
    logic [7:0] seq [8];
    seq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, seq[i]);
      tick();
      if (i == 6) begin
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL load_ready_7th got=%b exp=1", ld_ready); end
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL load_ready_8th got=%b exp=0", ld_ready); end
    checks++; if (pc_end !== 1'b0) begin failures++; $display("FAIL load_pc_end_idx0 got=%b exp=0", pc_end); end
  endtask

  task automatic test_run_halt();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, '0);
    tick();
    checks++; if (instr !== 32'h20080005) begin failures++; $display("FAIL run_instr0 got=%h exp=%h", instr, 32'h20080005); end
    checks++; if (pc_plus4 !== 32'd4) begin failures++; $display("FAIL run_pc_plus4 got=%h exp=%h", pc_plus4, 32'd4); end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL run_if_valid got=%b exp=1", if_valid); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 1'b0, '0);
    checks++; if (pc_end !== 1'b1) begin failures++; $display("FAIL run_pc_end_comb got=%b exp=1", pc_end); end
    tick();
    checks++; if (instr !== HALT) begin failures++; $display("FAIL run_instr_halt got=%h exp=%h", instr, HALT); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, '0);
    checks++; if (pc_end !== 1'b1) begin failures++; $display("FAIL done_pc_end got=%b exp=1", pc_end); end
    tick();
    checks++; if (instr !== 32'h0 || if_valid !== 1'b0) begin failures++; $display("FAIL done_nop got=%h/%b exp=%h/0", instr, if_valid, 32'h0); end
    tick();
    checks++; if (instr !== 32'h0 || pc_end !== 1'b1) begin failures++; $display("FAIL done_hold got=%h/%b exp=%h/1", instr, pc_end, 32'h0); end
  endtask

  task automatic test_stall();
    do_reset();
    load_word(32'h20080005); load_word(32'h12345678); load_word(HALT);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 1'b0, '0);
    tick();
    checks++; if (instr !== 32'h12345678 || pc_plus4 !== 32'd8) begin failures++; $display("FAIL stall_setup got=%h/%h exp=%h/%h", instr, pc_plus4, 32'h12345678, 32'd8); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'($urandom_range(0, 3)) << 2, 1'b0, '0);
      tick();
      checks++; if (instr !== 32'h12345678 || pc_plus4 !== 32'd8 || if_valid !== 1'b1) begin
        failures++; $display("FAIL stall_ena got=%h/%h/%b exp=%h/%h/1", instr, pc_plus4, if_valid, 32'h12345678, 32'd8); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, (i == 1), 32'($urandom_range(0, 3)) << 2, 1'b0, '0);
      tick();
      checks++; if (instr !== 32'h12345678 || pc_plus4 !== 32'd8 || if_valid !== 1'b1) begin
        failures++; $display("FAIL stall_db_ena got=%h/%h/%b exp=%h/%h/1", instr, pc_plus4, if_valid, 32'h12345678, 32'd8); end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, '0);
    tick();
    checks++; if (instr !== 32'h0 || if_valid !== 1'b0 || pc_plus4 !== 32'd8) begin
      failures++; $display("FAIL flush_ena0 got=%h/%b/%h exp=%h/0/%h", instr, if_valid, pc_plus4, 32'h0, 32'd8); end
  endtask

  task automatic test_flush_halt();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 1'b0, '0);
    checks++; if (pc_end !== 1'b1) begin failures++; $display("FAIL flush_halt_pc_end got=%b exp=1", pc_end); end
    tick();
    checks++; if (instr !== 32'h0 || if_valid !== 1'b0) begin failures++; $display("FAIL flush_halt_nop got=%h/%b exp=%h/0", instr, if_valid, 32'h0); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, '0);
    checks++; if (pc_end !== 1'b0) begin failures++; $display("FAIL flush_halt_not_done got=%b exp=0", pc_end); end
    tick();
    checks++; if (instr !== 32'h20080005) begin failures++; $display("FAIL flush_halt_resume got=%h exp=%h", instr, 32'h20080005); end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 1'b0, '0);
    checks++; if (pc_end !== 1'b1) begin failures++; $display("FAIL oor_pc_end got=%b exp=1", pc_end); end
    tick();
    checks++; if (instr !== HALT || pc_plus4 !== 32'h404) begin failures++; $display("FAIL oor_instr got=%h/%h exp=%h/%h", instr, pc_plus4, HALT, 32'h404); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, '0);
    checks++; if (pc_end !== 1'b1) begin failures++; $display("FAIL oor_done got=%b exp=1", pc_end); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 8'hAA); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 8'hBB); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 8'hCC); tick();
    checks++; if (ld_ready !== 1'b1 || instr !== 32'h0) begin failures++; $display("FAIL midword_reset got=%b/%h exp=1/%h", ld_ready, instr, 32'h0); end
    load_word(32'hDEADBEEF);
    load_word(HALT);
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL midword_run got=%b exp=0", ld_ready); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, '0);
    tick();
    checks++; if (instr !== 32'hDEADBEEF) begin failures++; $display("FAIL midword_mem0 got=%h exp=%h", instr, 32'hDEADBEEF); end
  endtask

  task automatic test_fill_memory();
    logic [31:0] w;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h0;
      exp_q.push_back(w);
      load_word(w);
      if (i == 254) begin
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_255 got=%b exp=1", ld_ready); end
      end
    end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_256 got=%b exp=0", ld_ready); end
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (k == 0) ? 255 : (k == 1) ? 0 : int'($urandom_range(1, 254));
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'(idx) << 2, 1'b0, '0);
      checks++; if (pc_end !== 1'b0) begin failures++; $display("FAIL fill_pc_end idx=%0d got=%b exp=0", idx, pc_end); end
      tick();
      checks++; if (instr !== exp_q[idx]) begin failures++; $display("FAIL fill_word idx=%0d got=%h exp=%h", idx, instr, exp_q[idx]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [31:0] p;
    int n;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      n = $urandom_range(1, 12);
      for (int i = 0; i <= n; i++) begin
        w = (i == n) ? HALT : $urandom();
        if (i != n && w == HALT) w = 32'h1;
        for (int b = 3; b >= 0; b--) begin
          while ($urandom_range(0, 3) == 0) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 8'($urandom()));
            tick();
          end
          drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, w[b*8 +: 8]);
          tick();
        end
      end
      checks++; if (ld_ready !== !m_loaded) begin failures++; $display("FAIL rand_loaded got=%b exp=%b", ld_ready, !m_loaded); end
      for (int c = 0; c < 80; c++) begin
        case ($urandom_range(0, 9))
          0: p = 32'h400 + $urandom_range(0, 4095);
          1: p = 32'hFFFF_FFFC;
          default: p = (32'($urandom_range(0, n + 2)) << 2) | 32'($urandom_range(0, 3));
        endcase
        drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 5) == 0), p, 1'($urandom_range(0, 1)), 8'($urandom()));
        checks++; if (pc_end !== m_pc_end()) begin failures++; $display("FAIL rand_pc_end c=%0d got=%b exp=%b", c, pc_end, m_pc_end()); end
        checks++; if (ld_ready !== !m_loaded) begin failures++; $display("FAIL rand_ld_ready c=%0d got=%b exp=%b", c, ld_ready, !m_loaded); end
        tick();
        checks++; if (instr !== exp_instr) begin failures++; $display("FAIL rand_instr c=%0d got=%h exp=%h", c, instr, exp_instr); end
        checks++; if (pc_plus4 !== exp_pp4) begin failures++; $display("FAIL rand_pc_plus4 c=%0d got=%h exp=%h", c, pc_plus4, exp_pp4); end
        checks++; if (if_valid !== exp_valid) begin failures++; $display("FAIL rand_if_valid c=%0d got=%b exp=%b", c, if_valid, exp_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_stall();
    test_flush_halt();
    test_out_of_range();
    test_reset_mid_word();
    test_fill_memory();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter bitsPC, default 32, meaning PC and instruction width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 256, meaning instruction memory depth in words.
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning halt instruction encoding.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  one clock; reset is synchronous and active-low.
- ena  in  1  hazard-unit enable; 0 = stall, hold IF/ID.
- db_ena  in  1  debug-unit clock enable; 0 = freeze fetch.
- flush  in  1  branch/jump taken; IF/ID becomes NOP.
- pc  in  bitsPC  current PC value.
- ld_valid  in  1  debug loader byte strobe.
- ld_byte  in  8  debug loader byte.
- instr  out  bitsPC  IF/ID instruction.
- pc_plus4  out  bitsPC  IF/ID PC+4.
- if_valid  out  1  IF/ID content is a real fetched instruction.
- pc_end  out  1  halt fetched or in progress; drives the PC stage's end input.
- ld_ready  out  1  high while in LOAD state.

Function
REQ-005 The FSM SHALL have states LOAD, RUN, DONE; reset enters LOAD.
REQ-006 In LOAD, each cycle with ld_valid=1 SHALL shift ld_byte into a 32-bit assembly register, first byte = bits [31:24] (big-endian).
REQ-007 After the 4th byte, the assembled word SHALL be written to mem[wr_ptr] on that edge, wr_ptr incremented, and the byte counter cleared.
REQ-008 LOAD->RUN SHALL occur on the edge that writes a word equal to HALT_WORD, or that writes at wr_ptr = MEM_DEPTH-1.
REQ-009 ld_valid SHALL be ignored in RUN and DONE; a partial word left at any transition is discarded.
REQ-010 Word index SHALL be pc[bitsPC-1:2]; pc[1:0] is ignored; an index >= MEM_DEPTH reads as HALT_WORD.
REQ-011 Memory read SHALL be synchronous; instr reflects pc one clock after sampling, with latency 1.
REQ-012 In RUN, the update priority SHALL be: db_ena=0 holds all; else flush loads instr=0, if_valid=0, pc_plus4 held; else ena=0 holds; else instr<=mem[idx], pc_plus4<=pc+4 (wraps mod 2^bitsPC), if_valid<=1.
REQ-013 The combinational pc_end SHALL be asserted in RUN when mem[idx]==HALT_WORD; it SHALL be 1 throughout DONE and 0 in LOAD.
REQ-014 RUN->DONE SHALL occur on an advancing edge (db_ena=1, ena=1, flush=0) that latches HALT_WORD into instr.
REQ-015 In DONE, the halt SHALL be followed by instr=0 and if_valid=0 on the next db_ena edge, then held until reset.
REQ-016 When flush and halt detection coincide, flush SHALL win: no DONE transition, and pc_end may still be high combinationally.

Reset
REQ-017 On an edge with reset=0, the block SHALL set state=LOAD, wr_ptr=0, byte counter=0, instr=0, pc_plus4=0, if_valid=0; pc_end=0 and ld_ready=1.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 Reset mid-word or mid-RUN SHALL take effect on that edge and override all other inputs.

Structure
REQ-020 A shared package SHALL hold HALT_WORD, the NOP encoding (0), and the FSM state enum.
REQ-021 Instruction memory SHALL be one sub-module, instr_mem: single write port, single synchronous read port, parameterised by MEM_DEPTH.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Load bytes 20,08,00,05, then FF,FF,FF,FF -> mem[0]=32'h20080005, mem[1]=HALT_WORD, RUN after 8th byte, ld_ready=0.
- RUN with pc=0 then 4, ena=db_ena=1 -> instr=32'h20080005 with pc_plus4=4 one clock later; next cycle instr=HALT_WORD, state DONE, pc_end=1, then instr=0 and if_valid=0.
- ena=0 for 3 cycles with pc changing -> instr, pc_plus4, if_valid unchanged; db_ena=0 gives the same result, and db_ena=0 also blocks flush.
- flush=1 with ena=0 -> instr=0, if_valid=0 next edge; flush on the HALT fetch cycle -> no DONE.
- pc=32'h00000400 (index 256) -> pc_end=1 and instr=HALT_WORD next edge.
- reset=0 after 2 bytes of a word -> LOAD, counter 0; then reloading 4 bytes writes mem[0].
